// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts one exception or MRET from commit, notifies the CSR block,
// flushes the pipeline for a fixed window, then redirects fetch to the handler or mepc.
module trap_ctrl #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0200,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        xcpt_valid_i,
  output logic        xcpt_ready_o,
  input  logic [4:0]  xcpt_code_i,
  input  logic [31:0] xcpt_pc_i,
  input  logic [31:0] xcpt_value_i,
  input  logic        mret_valid_i,
  input  logic [31:0] csr_mepc_i,
  output logic        csr_xcpt_o,
  output logic [4:0]  csr_xcpt_code_o,
  output logic [31:0] csr_xcpt_pc_o,
  output logic [31:0] csr_xcpt_value_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // The counter is loaded at the accept edge, so flush_o spans exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q;
  logic [3:0]  flush_cnt_q;
  logic        is_mret_q;
  logic [31:0] mepc_q;

  assign xcpt_ready_o = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values; reset is checked first so it overrides any trap in progress.
      state_q          <= ST_IDLE;
      flush_cnt_q      <= 4'd0;
      is_mret_q        <= 1'b0;
      mepc_q           <= 32'd0;
      csr_xcpt_o       <= 1'b0;
      csr_xcpt_code_o  <= 5'd0;
      csr_xcpt_pc_o    <= 32'd0;
      csr_xcpt_value_o <= 32'd0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'd0;
    end else begin
      csr_xcpt_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // An exception wins over a simultaneous MRET; the MRET is simply dropped.
          if (xcpt_valid_i) begin
            state_q          <= ST_FLUSH;
            is_mret_q        <= 1'b0;
            csr_xcpt_o       <= 1'b1;
            csr_xcpt_code_o  <= xcpt_code_i;
            csr_xcpt_pc_o    <= xcpt_pc_i;
            csr_xcpt_value_o <= xcpt_value_i;
            flush_o          <= 1'b1;
            flush_cnt_q      <= FLUSH_LOAD;
          end else if (mret_valid_i) begin
            state_q     <= ST_FLUSH;
            is_mret_q   <= 1'b1;
            mepc_q      <= csr_mepc_i;
            flush_o     <= 1'b1;
            flush_cnt_q <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            state_q          <= ST_REDIRECT;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= is_mret_q ? mepc_q : TRAP_VECTOR;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) begin
            state_q          <= ST_IDLE;
            redirect_valid_o <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          flush_o          <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
